fetch_unit: RTL

//   Program-counter and IF/ID stage sitting directly upstream of InstructionMemory.

---
 rtl/fetch_unit_pkg.sv | 23 ++
 rtl/fetch_unit_predecode.sv | 16 +
 rtl/fetch_unit.sv | 64 ++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the fetch stage and the branch predecoder.
package fetch_unit_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 64;

  localparam logic [5:0]        OPC_B            = 6'b000101;
  localparam logic [7:0]        OPC_CBZ          = 8'b10110100;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = '0;
  localparam logic [ADDR_W-1:0] PC_STEP          = 64'd4;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } ifid_t;

  // Byte offset of a B instruction: imm26 sign-extended, scaled by 4.
  function automatic logic [ADDR_W-1:0] b_offset(input logic [INSTR_W-1:0] instr);
    return {{(ADDR_W-28){instr[25]}}, instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_predecode.sv
// Combinational B-instruction detector and target calculator.
module fetch_predecode
  import fetch_unit_pkg::*;
(
  input  logic [ADDR_W-1:0]  pc,
  input  logic [INSTR_W-1:0] instr,
  output logic               is_b,
  output logic [ADDR_W-1:0]  b_target
);

  always_comb begin
    is_b     = (instr[31:26] == OPC_B);
    b_target = pc + b_offset(instr);
  end

endmodule

// File: rtl/fetch_unit.sv
// Program counter and IF/ID register with valid/ready handshake, B predecode
// and execute-stage redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter bit                PREDECODE_B = 1'b1
) (
  input  logic                CLK,
  input  logic                resetl,
  output logic [ADDR_W-1:0]   InstAddr,
  input  logic [INSTR_W-1:0]  InstData,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [INSTR_W-1:0]  out_instr,
  output logic [ADDR_W-1:0]   out_pc,
  output logic [31:0]         fetch_count
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] b_target;
  logic              is_b;
  logic              advance;
  ifid_t             ifid;

  fetch_predecode u_predecode (
    .pc       (pc),
    .instr    (InstData),
    .is_b     (is_b),
    .b_target (b_target)
  );

  always_comb begin
    advance = !out_valid || out_ready;
    next_pc = (PREDECODE_B && is_b) ? b_target : pc + PC_STEP;
  end

  // Redirect outranks the handshake: the word fetched this cycle is dropped.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      pc          <= RESET_PC;
      out_valid   <= 1'b0;
      ifid        <= '0;
      fetch_count <= '0;
    end else if (redirect_valid) begin
      pc        <= {redirect_pc[ADDR_W-1:2], 2'b00};
      out_valid <= 1'b0;
    end else if (advance) begin
      pc          <= next_pc;
      out_valid   <= 1'b1;
      ifid.instr  <= InstData;
      ifid.pc     <= pc;
      fetch_count <= fetch_count + 32'd1;
    end
  end

  assign InstAddr  = pc;
  assign out_instr = ifid.instr;
  assign out_pc    = ifid.pc;

endmodule
